// File: rtl/sdp_bram_stream_reader_if.sv
// Bus bundle for the BRAM stream reader: command port, BRAM port-B read side,
// output stream and status. Signal names mirror the block's external pins.
interface sdp_bram_stream_reader_if #(
  parameter int DATA_W = 75,
  parameter int ADDR_W = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
  logic              abort;
  logic [ADDR_W-1:0] bram_addrb;
  logic [DATA_W-1:0] bram_doutb;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, abort, bram_doutb, m_ready,
    output cmd_ready, bram_addrb, m_valid, m_data, m_last, busy, done
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, abort, bram_doutb, m_ready,
    input  cmd_ready, bram_addrb, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/sdp_bram_stream_reader.sv
// Burst read sequencer for a 1-cycle-latency BRAM port, streaming words out
// through a 2-entry buffer with full valid/ready backpressure.
module sdp_bram_stream_reader #(
  parameter int DATA_W = 75,
  parameter int ADDR_W = 10
) (
  input  logic                      clkb,
  input  logic                      rstb,
  sdp_bram_stream_reader_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              infl_q, infl_d;
  logic              tag_q, tag_d;
  logic              zl_q, zl_d;
  logic              done_c;

  logic [1:0][DATA_W:0] buf_q;
  logic                 rd_q, wr_q;
  logic [1:0]           cnt_q;
  logic [1:0]           credit;
  logic                 pop, push;

  assign pop    = (cnt_q != 2'd0) && bus.m_ready;
  assign push   = infl_q;
  // Words in the buffer plus the one still coming out of the BRAM.
  assign credit = cnt_q + {1'b0, infl_q};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    infl_d  = 1'b0;
    tag_d   = tag_q;
    zl_d    = 1'b0;
    done_c  = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_d = bus.cmd_addr;
            rem_d  = bus.cmd_len;
            if (bus.cmd_len == '0) zl_d = 1'b1;
            else                   state_d = RUN;
          end
        end
        RUN: begin
          if (credit < 2'd2 || (credit == 2'd2 && pop)) begin
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
            infl_d = 1'b1;
            tag_d  = (rem_q == (ADDR_W+1)'(1));
            if (rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (!infl_q && cnt_q == 2'd0) begin
            state_d = IDLE;
            done_c  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clkb or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      infl_q  <= 1'b0;
      tag_q   <= 1'b0;
      zl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      infl_q  <= infl_d;
      tag_q   <= tag_d;
      zl_q    <= zl_d;
    end
  end

  // Entries hold {last, data}; the credit rule keeps pushes from overflowing.
  always_ff @(posedge clkb or negedge rstb) begin
    if (!rstb) begin
      buf_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (bus.abort) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_q] <= {tag_q, bus.bram_doutb};
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.bram_addrb = addr_q;
  assign bus.m_valid    = (cnt_q != 2'd0);
  assign bus.m_data     = buf_q[rd_q][DATA_W-1:0];
  assign bus.m_last     = buf_q[rd_q][DATA_W];
  assign bus.done       = done_c | zl_q;
endmodule
